// File: rtl/divider_result_collector_pkg.sv
// Shared defaults and helpers for the divider result collector slice.
// Width defaults match the divider cell chain (N cells, M-bit divisor).
package divider_result_collector_pkg;

  localparam int N_DEF     = 5;
  localparam int M_DEF     = 3;
  localparam int DEPTH_DEF = 4;

  // Number of set bits, used to count operations still inside the cell chain.
  function automatic int popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/divider_result_collector_if.sv
// Cell-chain taps and result stream of the divider result collector.
// out_valid/out_ready: a result transfers on every rising edge where both are
// high; out_valid never depends on out_ready, and quotient/remainder hold the
// head entry steadily while out_valid is high and out_ready is low.
interface divider_result_collector_if
  import divider_result_collector_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
);

  logic [N-1:0] ck_in;
  logic [N-1:0] q_in;
  logic [M-1:0] rem_in;
  logic         issue_ok;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         ovf;

  modport master (
    output ck_in, q_in, rem_in, out_ready,
    input  issue_ok, out_valid, quotient, remainder, ovf
  );

  modport slave (
    input  ck_in, q_in, rem_in, out_ready,
    output issue_ok, out_valid, quotient, remainder, ovf
  );

endinterface

// File: rtl/divider_result_collector_deskew.sv
// 1-bit delay line of DLY stages with asynchronous clear; DLY=0 is a wire.
// Shifts every cycle, so each lane lines up with the last cell of the chain.
module divider_result_collector_deskew #(
  parameter int DLY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (DLY == 0) begin : g_wire
      assign q = d;
    end else begin : g_sr
      logic [DLY-1:0] sr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr <= '0;
        end else begin
          sr[0] <= d;
          for (int i = 1; i < DLY; i++) sr[i] <= sr[i-1];
        end
      end

      assign q = sr[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/divider_result_collector.sv
// De-skews the per-cell quotient bits of the pipelined divider into one word,
// queues {quotient, remainder} in a small FIFO and gates new issues upstream.
module divider_result_collector
  import divider_result_collector_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int M     = M_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  divider_result_collector_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int W  = N + M;

  // q_dsk is indexed by quotient bit: cell s drives bit N-1-s.
  logic [N-1:0] q_dsk;

  for (genvar s = 0; s < N - 1; s++) begin : g_lane
    divider_result_collector_deskew #(.DLY(N - 1 - s)) u_deskew (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.q_in[s]),
      .q     (q_dsk[N-1-s])
    );
  end
  assign q_dsk[0] = bus.q_in[N-1];

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   free;
  logic          ovf_r;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic [W-1:0]  head;

  assign push  = bus.ck_in[N-1];
  assign pop   = bus.out_valid && bus.out_ready;
  assign full  = (count == (PW+1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !wr_en) count <= count - (PW+1)'(1);
      if (push && !wr_en) ovf_r <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {q_dsk, bus.rem_in};
  end

  assign head          = mem[rd_ptr];
  assign bus.out_valid = (count != '0);
  assign bus.quotient  = bus.out_valid ? head[W-1:M] : '0;
  assign bus.remainder = bus.out_valid ? head[M-1:0] : '0;
  assign bus.ovf       = ovf_r;

  // Every operation still in the chain may need a slot; this cycle's pop is ignored.
  assign free         = (PW+1)'(DEPTH) - count;
  assign bus.issue_ok = int'(free) > popcount(32'(bus.ck_in));

endmodule

// File: tb/tb_divider_result_collector.sv
// Randomized bench for divider_result_collector against a queue/history model.
// Model: quotient bits are taken from the recorded q_in history, results kept in a queue.
module tb_divider_result_collector;
  import divider_result_collector_pkg::*;

  localparam int N     = 5;
  localparam int M     = 3;
  localparam int DEPTH = 4;
  localparam int W     = N + M;

  typedef struct {
    int           stage;
    logic [N-1:0] q;
    logic [M-1:0] r;
  } op_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_result_collector_if #(.N(N), .M(M)) bus ();

  divider_result_collector #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- model state ----------------
  op_t          ops[$];      // operations travelling through the cell chain
  logic [W-1:0] exp_q[$];    // expected FIFO contents, head first
  logic [W-1:0] arith_q[$];  // dividend/divisor results in issue order
  logic [N-1:0] q_hist[$];   // q_in of the last N cycles, newest last
  logic         exp_ovf;

  logic [N-1:0] ck_drv;
  logic [N-1:0] q_drv;
  logic [M-1:0] rem_drv;
  logic [W+1:0] exp_o;
  logic [W+1:0] got_o;
  logic [W-1:0] exp_r;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic model_issue_ok();
    return (DEPTH - exp_q.size()) > $countones(ck_drv);
  endfunction

  function automatic logic [W+1:0] model_out();
    logic         v;
    logic [W-1:0] h;
    v = (exp_q.size() > 0);
    h = v ? exp_q[0] : '0;
    return {v, h, exp_ovf};
  endfunction

  task automatic model_reset();
    ops.delete();
    exp_q.delete();
    arith_q.delete();
    q_hist.delete();
    for (int i = 0; i < N; i++) q_hist.push_back('0);
    exp_ovf = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue_op(input int d, input int v);
    op_t o;
    o.stage = 0;
    o.q     = N'(d / v);
    o.r     = M'(d % v);
    ops.push_back(o);
    arith_q.push_back({o.q, o.r});
  endtask

  // Raw last-cell strobe; earlier cells are not driven for this entry.
  task automatic inject_last(input logic [N-1:0] q, input logic [M-1:0] r);
    op_t o;
    o.stage = N - 1;
    o.q     = q;
    o.r     = r;
    ops.push_back(o);
  endtask

  task automatic drive_cycle();
    ck_drv  = '0;
    q_drv   = '0;
    rem_drv = M'($urandom);
    foreach (ops[i]) begin
      ck_drv[ops[i].stage] = 1'b1;
      q_drv[ops[i].stage]  = ops[i].q[N-1-ops[i].stage];
      if (ops[i].stage == N - 1) rem_drv = ops[i].r;
    end
    bus.ck_in  = ck_drv;
    bus.q_in   = q_drv;
    bus.rem_in = rem_drv;
    #1;
  endtask

  task automatic clock_cycle();
    logic         pop_m;
    logic         push_m;
    logic [W-1:0] ent;
    pop_m  = (exp_q.size() > 0) && bus.out_ready;
    push_m = ck_drv[N-1];
    q_hist.push_back(q_drv);
    for (int s = 0; s < N; s++) ent[W-1-s] = q_hist[1+s][s];
    ent[M-1:0] = rem_drv;
    void'(q_hist.pop_front());
    @(posedge clk);
    if (pop_m) void'(exp_q.pop_front());
    if (push_m) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(ent);
      else                      exp_ovf = 1'b1;
    end
    foreach (ops[i]) ops[i].stage++;
    while (ops.size() > 0 && ops[0].stage >= N) void'(ops.pop_front());
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [N-1:0] ck;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do ck = N'($urandom); while ($countones(ck) >= DEPTH);
      bus.ck_in  = ck;
      bus.q_in   = N'($urandom);
      bus.rem_in = M'($urandom);
      @(posedge clk);
      #1;
      n_vec++;
      if ({bus.out_valid, bus.ovf, bus.issue_ok, bus.quotient, bus.remainder} !== {3'b001, {W{1'b0}}}) begin
        n_err++;
        $display("FAIL reset_hold: got v=%b ovf=%b ok=%b q=%b r=%0d, want v=0 ovf=0 ok=1 q=0 r=0",
                 bus.out_valid, bus.ovf, bus.issue_ok, bus.quotient, bus.remainder);
      end
    end
    bus.ck_in  = '0;
    bus.q_in   = '0;
    bus.rem_in = '0;
    model_reset();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single_op();
    bus.out_ready = 1'b0;
    issue_op(23, 3);
    for (int c = 0; c < 5; c++) begin
      drive_cycle();
      n_vec++;
      if (bus.issue_ok !== model_issue_ok()) begin
        n_err++;
        $display("FAIL single_issue_ok c%0d: got %b want %b", c, bus.issue_ok, model_issue_ok());
      end
      clock_cycle();
      exp_o = model_out();
      got_o = {bus.out_valid, bus.quotient, bus.remainder, bus.ovf};
      n_vec++;
      if (got_o !== exp_o || bus.out_valid !== (c == 4)) begin
        n_err++;
        $display("FAIL single_out c%0d: got %h want %h (valid,quotient,remainder,ovf)", c, got_o, exp_o);
      end
    end
    n_vec++;
    if ({bus.quotient, bus.remainder} !== {5'b00111, 3'd2}) begin
      n_err++;
      $display("FAIL single_value: got q=%b r=%0d want q=00111 r=2", bus.quotient, bus.remainder);
    end
    bus.out_ready = 1'b1;
    drive_cycle();
    exp_r = arith_q.pop_front();
    n_vec++;
    if ({bus.quotient, bus.remainder} !== exp_r) begin
      n_err++;
      $display("FAIL single_pop: got %h want %h", {bus.quotient, bus.remainder}, exp_r);
    end
    clock_cycle();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_empty: got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int pops;
    int first_pop;
    int last_pop;
    pops = 0; first_pop = -1; last_pop = -1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) issue_op(31 - c, 7);
      drive_cycle();
      n_vec++;
      if (bus.issue_ok !== model_issue_ok()) begin
        n_err++;
        $display("FAIL b2b_issue_ok c%0d: got %b want %b", c, bus.issue_ok, model_issue_ok());
      end
      if (exp_q.size() > 0) begin
        exp_r = arith_q.pop_front();
        pops++;
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        n_vec++;
        if ({bus.quotient, bus.remainder} !== exp_r) begin
          n_err++;
          $display("FAIL b2b_order c%0d: got %h want %h", c, {bus.quotient, bus.remainder}, exp_r);
        end
      end
      clock_cycle();
      exp_o = model_out();
      got_o = {bus.out_valid, bus.quotient, bus.remainder, bus.ovf};
      n_vec++;
      if (got_o !== exp_o) begin
        n_err++;
        $display("FAIL b2b_out c%0d: got %h want %h (valid,quotient,remainder,ovf)", c, got_o, exp_o);
      end
    end
    n_vec++;
    if (pops != 4 || first_pop != 5 || last_pop != 8) begin
      n_err++;
      $display("FAIL b2b_timing: got pops=%0d first=%0d last=%0d want 4/5/8", pops, first_pop, last_pop);
    end
  endtask

  task automatic test_backpressure();
    int  ok_cycles;
    logic do_issue;
    ok_cycles = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      drive_cycle();
      do_issue = model_issue_ok();
      if (bus.issue_ok === 1'b1) ok_cycles++;
      n_vec++;
      if (bus.issue_ok !== do_issue) begin
        n_err++;
        $display("FAIL bp_issue_ok c%0d: got %b want %b", c, bus.issue_ok, do_issue);
      end
      clock_cycle();
      if (do_issue) issue_op($urandom_range(0, 31), $urandom_range(1, 7));
      exp_o = model_out();
      got_o = {bus.out_valid, bus.quotient, bus.remainder, bus.ovf};
      n_vec++;
      if (got_o !== exp_o) begin
        n_err++;
        $display("FAIL bp_out c%0d: got %h want %h (valid,quotient,remainder,ovf)", c, got_o, exp_o);
      end
    end
    n_vec++;
    if (ok_cycles != DEPTH || bus.issue_ok !== 1'b0 || bus.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full: got accepted=%0d ok=%b ovf=%b want 4/0/0", ok_cycles, bus.issue_ok, bus.ovf);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive_cycle();
      if (exp_q.size() > 0) begin
        exp_r = arith_q.pop_front();
        n_vec++;
        if ({bus.quotient, bus.remainder} !== exp_r) begin
          n_err++;
          $display("FAIL bp_drain c%0d: got %h want %h", c, {bus.quotient, bus.remainder}, exp_r);
        end
      end
      clock_cycle();
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty: got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic do_issue;
    for (int c = 0; c < 160; c++) begin
      bus.out_ready = (c >= 150) ? 1'b1 : ($urandom_range(0, 2) != 0);
      drive_cycle();
      do_issue = model_issue_ok() && (c < 145) && ($urandom_range(0, 3) != 0);
      n_vec++;
      if (bus.issue_ok !== model_issue_ok()) begin
        n_err++;
        $display("FAIL rand_issue_ok c%0d: got %b want %b", c, bus.issue_ok, model_issue_ok());
      end
      if (exp_q.size() > 0 && bus.out_ready) begin
        exp_r = arith_q.pop_front();
        n_vec++;
        if ({bus.quotient, bus.remainder} !== exp_r) begin
          n_err++;
          $display("FAIL rand_pop c%0d: got %h want %h", c, {bus.quotient, bus.remainder}, exp_r);
        end
      end
      clock_cycle();
      if (do_issue) issue_op($urandom_range(0, 31), $urandom_range(1, 7));
      exp_o = model_out();
      got_o = {bus.out_valid, bus.quotient, bus.remainder, bus.ovf};
      n_vec++;
      if (got_o !== exp_o) begin
        n_err++;
        $display("FAIL rand_out c%0d: got %h want %h (valid,quotient,remainder,ovf)", c, got_o, exp_o);
      end
    end
  endtask

  task automatic test_overflow();
    logic [N-1:0] q0;
    logic [M-1:0] r0;
    bus.out_ready = 1'b0;
    q0 = N'($urandom);
    r0 = M'($urandom);
    for (int c = 0; c < 8; c++) begin
      if (c == 0) inject_last(q0, r0);
      else if (c < 5) inject_last(N'($urandom), M'($urandom));
      drive_cycle();
      clock_cycle();
      exp_o = model_out();
      got_o = {bus.out_valid, bus.quotient, bus.remainder, bus.ovf};
      n_vec++;
      if (got_o !== exp_o || bus.ovf !== (c >= 4)) begin
        n_err++;
        $display("FAIL ovf_out c%0d: got %h want %h (valid,quotient,remainder,ovf)", c, got_o, exp_o);
      end
    end
    n_vec++;
    if ({bus.quotient, bus.remainder} !== {{(N-1){1'b0}}, q0[0], r0}) begin
      n_err++;
      $display("FAIL ovf_head: got q=%b r=%0d want q=%b r=%0d",
               bus.quotient, bus.remainder, {{(N-1){1'b0}}, q0[0]}, r0);
    end
  endtask

  task automatic test_full_push_pop();
    // restart from a clean FIFO so ovf starts at 0
    rst_n = 1'b0;
    bus.ck_in = '0; bus.q_in = '0; bus.rem_in = '0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      inject_last(N'($urandom), M'($urandom));
      if (c == 4) bus.out_ready = 1'b1;
      drive_cycle();
      clock_cycle();
      exp_o = model_out();
      got_o = {bus.out_valid, bus.quotient, bus.remainder, bus.ovf};
      n_vec++;
      if (got_o !== exp_o) begin
        n_err++;
        $display("FAIL fpp_out c%0d: got %h want %h (valid,quotient,remainder,ovf)", c, got_o, exp_o);
      end
    end
    bus.out_ready = 1'b0;
    drive_cycle();
    n_vec++;
    if (bus.issue_ok !== 1'b0 || bus.ovf !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL fpp_still_full: got ok=%b ovf=%b valid=%b want 0/0/1", bus.issue_ok, bus.ovf, bus.out_valid);
    end
    // put ones into the delay lines, then reset mid-stream
    issue_op(31, 1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      clock_cycle();
      drive_cycle();
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.quotient, bus.remainder, bus.ovf} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b q=%b r=%0d ovf=%b want all 0",
               bus.out_valid, bus.quotient, bus.remainder, bus.ovf);
    end
    bus.ck_in = '0; bus.q_in = '0; bus.rem_in = '0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    inject_last(5'b00001, 3'd5);
    drive_cycle();
    clock_cycle();
    n_vec++;
    if ({bus.out_valid, bus.quotient, bus.remainder} !== {1'b1, 5'b00001, 3'd5} ||
        model_out() !== {bus.out_valid, bus.quotient, bus.remainder, bus.ovf}) begin
      n_err++;
      $display("FAIL deskew_cleared: got v=%b q=%b r=%0d want v=1 q=00001 r=5",
               bus.out_valid, bus.quotient, bus.remainder);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.ck_in = '0;
    bus.q_in = '0;
    bus.rem_in = '0;
    bus.out_ready = 1'b0;
    model_reset();
    ck_drv = '0;
    q_drv = '0;
    rem_drv = '0;
    exp_o = '0;
    got_o = '0;
    exp_r = '0;
    #1;
    test_reset();
    test_single_op();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_overflow();
    test_full_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
